console_apb_writer: RTL

Upstream feeder for the simulation console sink. It accepts a byte stream over a valid/ready handshake, buffers it in a small FIFO, and issues one APB write per byte to `CONSOLE_ADDR`. It sits between a core-side character source (boot ROM printf shim or test sequencer) and the APB console slave. It owns the full APB master protocol: SETUP/ACCESS sequencing, wait states and error capture.

---
 rtl/console_pkg.sv | 12 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/console_apb_writer.sv | 110 +++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared types and constants for the APB console writer and console slave.
package console_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h1000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty. It also exposes the head
// entry as it will be after this edge, for registered consumers.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   level_after_pop;
  logic             push_ok, pop_ok;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign push_ok  = push_i && !full_o;
  assign pop_ok   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + (AddrW+1)'(push_ok);
  assign rd_ptr_d = rd_ptr_q + (AddrW+1)'(pop_ok);

  // If the pop drains the buffer, the only possible next head is the byte written now.
  assign level_after_pop = level_o - (AddrW+1)'(pop_ok);
  assign head_next_o     = (level_after_pop == '0) ? wdata_i : mem_q[rd_ptr_d[AddrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/console_apb_writer.sv
// Byte-stream to APB bridge: buffers characters and writes each one to a fixed console
// address, with wait-state support and a sticky slave-error flag.
module console_apb_writer
  import console_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned LvlW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            char_valid_i,
  input  logic [7:0]      char_data_i,
  output logic            char_ready_o,
  output logic            psel_o,
  output logic            penable_o,
  output logic            pwrite_o,
  output logic [31:0]     paddr_o,
  output logic [31:0]     pwdata_o,
  input  logic            pready_i,
  input  logic            pslverr_i,
  output logic            busy_o,
  output logic            err_o,
  output logic [LvlW-1:0] level_o
);

  apb_state_e      state_q, state_d;
  logic            push, pop, full, empty;
  logic [7:0]      head_next;
  logic [LvlW-1:0] level;
  logic            psel_d, penable_d, pwrite_d, err_d;
  logic [31:0]     paddr_d, pwdata_d;
  logic            psel_q, penable_q, pwrite_q, err_q;
  logic [31:0]     paddr_q, pwdata_q;

  assign push = char_valid_i && !full;
  assign pop  = (state_q == StAccess) && pready_i;

  sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .wdata_i    (char_data_i),
    .pop_i      (pop),
    .head_next_o(head_next),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!empty) state_d = StSetup;
      StSetup:  state_d = StAccess;
      // A same-cycle push keeps the chain going even when the pop drains the buffer.
      StAccess: if (pready_i) state_d = (level > LvlW'(1) || push) ? StSetup : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    psel_d    = (state_d != StIdle);
    penable_d = (state_d == StAccess);
    pwrite_d  = psel_d;
    paddr_d   = psel_d ? CONSOLE_ADDR : 32'h0;
    pwdata_d  = psel_d ? {24'h0, head_next} : 32'h0;
    err_d     = err_q || (pop && pslverr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      err_q     <= err_d;
    end
  end

  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign pwrite_o     = pwrite_q;
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign err_o        = err_q;
  assign level_o      = level;
  assign char_ready_o = !full;
  assign busy_o       = !empty || (state_q != StIdle);

endmodule
